// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding and default geometry for param_memory
package mem_pkg;
  typedef enum logic {CLEAR, READY} state_e;
  localparam int MEM_DATA_W = 64;
  localparam int MEM_DEPTH  = 256;
  localparam int MEM_ADDR_W = 64;
endpackage

// File: rtl/mem_array.sv
// mem_array: word storage with one byte-enabled write port and a registered read port
module mem_array #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  output logic [DATA_W-1:0]   rdata
);
  localparam int NB = DATA_W / 8;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  // read-first: capture the old word on a read, otherwise hold
  always_comb rdata_d = re ? mem[idx] : rdata_q;
  // read register plus byte-lane writes
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    for (int b = 0; b < NB; b++)
      if (we && wbe[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/param_memory.sv
// param_memory: self-clearing single-port data memory with range-checked valid/ready requests; MEM_BYTE_WE_EN adds byte write enables
module param_memory
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int DEPTH  = MEM_DEPTH,
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef MEM_BYTE_WE_EN
  input  logic [DATA_W/8-1:0] req_be,
`endif
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int NB    = DATA_W / 8;
  state_e            state_q, state_d;
  logic [IDX_W-1:0]  clr_q, clr_d;
  logic              vld_q, vld_d, rd_q, rd_d, err_q, err_d;
  logic [DATA_W-1:0] hold_q, hold_d, arr_rdata, wdata;
  logic [IDX_W-1:0]  idx;
  logic [NB-1:0]     be, wbe;
  logic              clearing, in_range, accept, we, re;
`ifdef MEM_BYTE_WE_EN
  assign be = req_be;
`else
  assign be = '1;
`endif
  // handshake and full-width range check (no aliasing of high address bits)
  always_comb begin
    clearing  = state_q == CLEAR;
    in_range  = req_adr < ADDR_W'(DEPTH);
    req_ready = !clearing && !rst;
    busy      = clearing || rst;
    accept    = req_valid && req_ready;
  end
  // storage port: the clear sequence owns the write port while clearing
  always_comb begin
    we    = clearing ? 1'b1 : accept && req_we && in_range;
    re    = accept && !req_we && in_range;
    idx   = clearing ? clr_q : req_adr[IDX_W-1:0];
    wdata = clearing ? '0 : req_wdata;
    wbe   = clearing ? '1 : be;
  end
  // state, clear pointer and response bookkeeping
  always_comb begin
    state_d = rst ? CLEAR : (clearing && clr_q == IDX_W'(DEPTH - 1)) ? READY : state_q;
    clr_d   = (rst || !clearing || clr_q == IDX_W'(DEPTH - 1)) ? '0 : clr_q + 1'b1;
    vld_d   = accept;
    rd_d    = accept && !req_we;
    err_d   = accept && !in_range;
    hold_d  = rst ? '0 : rsp_rdata;
  end
  // read data follows the array on a read response, zero on an erroring read, else holds
  always_comb begin
    rsp_valid = vld_q;
    rsp_err   = vld_q && err_q;
    rsp_rdata = (vld_q && rd_q) ? (err_q ? '0 : arr_rdata) : hold_q;
  end
  // registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_q   <= '0;
      vld_q   <= 1'b0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      vld_q   <= vld_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end
  mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .we    (we),
    .re    (re),
    .idx   (idx),
    .wdata (wdata),
    .wbe   (wbe),
    .rdata (arr_rdata)
  );
endmodule

// File: tb/tb_param_memory.sv
// tb_param_memory: directed vector table plus multi-cycle sequences for param_memory
module tb_param_memory;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [63:0] req_adr = '0;
  logic [63:0] req_wdata = '0;
`ifdef MEM_BYTE_WE_EN
  logic [7:0]  req_be = 8'hFF;
`endif
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  param_memory dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_wdata (req_wdata),
`ifdef MEM_BYTE_WE_EN
    .req_be    (req_be),
`endif
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  typedef struct {
    logic        we;
    logic [63:0] adr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_req(input string name, input logic we, input logic [63:0] adr,
                        input logic [63:0] wd, input logic [63:0] exp_rd, input logic exp_err);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_adr   = adr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk({name, " valid"}, 64'(rsp_valid), 64'd1);
    chk({name, " rdata"}, rsp_rdata, exp_rd);
    chk({name, " err"}, 64'(rsp_err), 64'(exp_err));
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!req_ready && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, " cycles to ready"}, 64'(n), 64'd256);
    chk({name, " busy low"}, 64'(busy), 64'd0);
  endtask

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{1'b0, 64'h80,          64'h0,                   64'h0,                   1'b0};
    vecs[1]  = '{1'b1, 64'h5,           64'hDEADBEEF_00000001,   64'h0,                   1'b0};
    vecs[2]  = '{1'b0, 64'h5,           64'h0,                   64'hDEADBEEF_00000001,   1'b0};
    vecs[3]  = '{1'b1, 64'h1,           64'h11,                  64'hDEADBEEF_00000001,   1'b0};
    vecs[4]  = '{1'b1, 64'h2,           64'h22,                  64'hDEADBEEF_00000001,   1'b0};
    vecs[5]  = '{1'b1, 64'h3,           64'h33,                  64'hDEADBEEF_00000001,   1'b0};
    vecs[6]  = '{1'b1, 64'h0,           64'hAAAA,                64'hDEADBEEF_00000001,   1'b0};
    vecs[7]  = '{1'b1, 64'd256,         64'h1234,                64'hDEADBEEF_00000001,   1'b1};
    vecs[8]  = '{1'b0, 64'h1_0000_0000, 64'h0,                   64'h0,                   1'b1};
    vecs[9]  = '{1'b0, 64'h0,           64'h0,                   64'hAAAA,                1'b0};
    vecs[10] = '{1'b0, 64'd255,         64'h0,                   64'h0,                   1'b0};
    vecs[11] = '{1'b1, 64'd255,         64'h5555,                64'h0,                   1'b0};
    vecs[12] = '{1'b0, 64'd255,         64'h0,                   64'h5555,                1'b0};
    vecs[13] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,           64'h0,                   1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_rdata", rsp_rdata, 64'd0);
    chk("reset rsp_err", 64'(rsp_err), 64'd0);
    chk("reset busy", 64'(busy), 64'd1);
    chk("reset req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready("initial clear");

    for (int i = 0; i < 14; i++)
      do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err);
    @(posedge clk);
    #1;
    chk("pulse ends", 64'(rsp_valid), 64'd0);
    chk("rdata holds", rsp_rdata, 64'd0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_adr   = 64'(i + 1);
      @(posedge clk);
      #1;
      chk($sformatf("b2b%0d valid", i), 64'(rsp_valid), 64'd1);
      chk($sformatf("b2b%0d rdata", i), rsp_rdata, 64'h11 * 64'(i + 1));
    end
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b end valid", 64'(rsp_valid), 64'd0);
    chk("b2b hold rdata", rsp_rdata, 64'h33);

    do_req("wr7", 1'b1, 64'h7, 64'h77, 64'h33, 1'b0);
    do_req("rd7", 1'b0, 64'h7, 64'h0, 64'h77, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_adr = 64'h7;
    @(posedge clk);
    #1;
    chk("rst drops req", 64'(rsp_valid), 64'd0);
    chk("rst clears rdata", rsp_rdata, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("mid clear busy", 64'(busy), 64'd1);
    chk("mid clear ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready("restarted clear");
    do_req("rd7 cleared", 1'b0, 64'h7, 64'h0, 64'h0, 1'b0);
    do_req("rd5 cleared", 1'b0, 64'h5, 64'h0, 64'h0, 1'b0);

`ifdef MEM_BYTE_WE_EN
    req_be = 8'hFF;
    do_req("be ones", 1'b1, 64'h9, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0);
    req_be = 8'h0F;
    do_req("be low", 1'b1, 64'h9, 64'h0, 64'h0, 1'b0);
    req_be = 8'h00;
    do_req("be none", 1'b1, 64'h9, 64'h0, 64'h0, 1'b0);
    req_be = 8'h00;
    do_req("be read", 1'b0, 64'h9, 64'h0, 64'hFFFF_FFFF_0000_0000, 1'b0);
    req_be = 8'hFF;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
